// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: bus command codes, arbitration sides and tag table size.
// The bus command macros are defined only if no other header has already provided them.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

package mem_arb_pkg;

  typedef enum logic {ARB_I, ARB_D} arb_side_e;

  localparam int MEM_TAG_NUM = 16;
  localparam int MEM_TAG_W   = $clog2(MEM_TAG_NUM);

  function automatic arb_side_e other_side(input arb_side_e s);
    return (s == ARB_I) ? ARB_D : ARB_I;
  endfunction

endpackage

// File: rtl/mem_tag_tracker.sv
// Records which side owns each in-flight memory tag and steers returns back to that side.
// Flags a sticky error when a return names an idle tag or an accept reuses a busy one.
module mem_tag_tracker
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_vld,
  input  logic [MEM_TAG_W-1:0] acc_tag,
  input  arb_side_e            acc_side,
  input  logic [MEM_TAG_W-1:0] ret_tag,
  output logic                 i_tag_vld,
  output logic                 d_tag_vld,
  output logic                 err_tag
);

  logic [MEM_TAG_NUM-1:0] vld_r;
  arb_side_e              owner_r [MEM_TAG_NUM];

  logic ret_any;
  logic ret_hit;
  logic ret_bad;
  logic acc_dup;

  assign ret_any = (ret_tag != '0);
  assign ret_hit = ret_any && vld_r[ret_tag];
  assign ret_bad = ret_any && !vld_r[ret_tag];
  // A tag returning in the same cycle it is handed out again is a legal recycle, not a reuse.
  assign acc_dup = acc_vld && vld_r[acc_tag] && !(ret_hit && (ret_tag == acc_tag));

  assign i_tag_vld = ret_hit && (owner_r[ret_tag] == ARB_I);
  assign d_tag_vld = ret_hit && (owner_r[ret_tag] == ARB_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r   <= '0;
      err_tag <= 1'b0;
      for (int t = 0; t < MEM_TAG_NUM; t++) begin
        owner_r[t] <= ARB_I;
      end
    end else begin
      if (ret_hit) begin
        vld_r[ret_tag] <= 1'b0;
      end
      // Later assignment lets a same-cycle re-accept win over the return clear.
      if (acc_vld) begin
        vld_r[acc_tag]   <= 1'b1;
        owner_r[acc_tag] <= acc_side;
      end
      if (ret_bad || acc_dup) begin
        err_tag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the off-chip memory port between the I-fetch and D-memory sides with weighted round-robin
// plus starvation override. Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int I_WEIGHT     = 2,
  parameter int D_WEIGHT     = 2,
  parameter int STARVE_LIMIT = 8
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Imem_command_i,
  input  logic [63:0] Imem_addr_i,
  output logic [3:0]  Imem2proc_response_o,
  output logic        Imem_tag_vld_o,
  input  logic [1:0]  Dmem_command_i,
  input  logic [63:0] Dmem_addr_i,
  input  logic [63:0] Dmem_data_i,
  output logic [3:0]  Dmem2proc_response_o,
  output logic        Dmem_tag_vld_o,
  input  logic [3:0]  mem2proc_response_i,
  input  logic [3:0]  mem2proc_tag_i,
  output logic [1:0]  proc2mem_command_o,
  output logic [63:0] proc2mem_addr_o,
  output logic [63:0] proc2mem_data_o,
  output logic        err_tag_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_I_grant_o,
  output logic [PERF_W-1:0] perf_D_grant_o,
  output logic [PERF_W-1:0] perf_conflict_o
`endif
);

  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int WMAX = (I_WEIGHT > D_WEIGHT) ? I_WEIGHT : D_WEIGHT;
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] I_WT       = WW'(I_WEIGHT);
  localparam logic [WW-1:0] D_WT       = WW'(D_WEIGHT);

  arb_side_e     prio_r;
  arb_side_e     grant;
  logic [WW-1:0] win_cnt_r;
  logic [SW-1:0] starve_i_r;
  logic [SW-1:0] starve_d_r;

  logic req_i;
  logic req_d;
  logic req_any;
  logic contend;
  logic starved_i;
  logic starved_d;
  logic override;
  logic accept;
  logic acc_i;
  logic acc_d;

  assign req_i     = (Imem_command_i != `BUS_NONE);
  assign req_d     = (Dmem_command_i != `BUS_NONE);
  assign req_any   = req_i || req_d;
  assign contend   = req_i && req_d;
  assign starved_i = (starve_i_r >= STARVE_MAX);
  assign starved_d = (starve_d_r >= STARVE_MAX);
  assign override  = starved_i ^ starved_d;

  always_comb begin
    grant = ARB_I;
    if (contend) begin
      if (override) begin
        grant = starved_d ? ARB_D : ARB_I;
      end else begin
        grant = prio_r;
      end
    end else if (req_d) begin
      grant = ARB_D;
    end
  end

  assign accept = rst && req_any && (mem2proc_response_i != 4'd0);
  assign acc_i  = accept && (grant == ARB_I);
  assign acc_d  = accept && (grant == ARB_D);

  // With no requester the I side is selected, so the command is BUS_NONE and the address is Imem_addr_i.
  assign proc2mem_command_o   = !rst ? `BUS_NONE :
                                ((grant == ARB_D) ? Dmem_command_i : Imem_command_i);
  assign proc2mem_addr_o      = (grant == ARB_D) ? Dmem_addr_i : Imem_addr_i;
  assign proc2mem_data_o      = Dmem_data_i;
  assign Imem2proc_response_o = (rst && req_i && (grant == ARB_I)) ? mem2proc_response_i : 4'd0;
  assign Dmem2proc_response_o = (rst && req_d && (grant == ARB_D)) ? mem2proc_response_i : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_r     <= ARB_I;
      win_cnt_r  <= '0;
      starve_i_r <= '0;
      starve_d_r <= '0;
    end else begin
      if (contend) begin
        if (override) begin
          prio_r    <= other_side(grant);
          win_cnt_r <= '0;
        end else if ((win_cnt_r + 1'b1) == ((prio_r == ARB_I) ? I_WT : D_WT)) begin
          prio_r    <= other_side(prio_r);
          win_cnt_r <= '0;
        end else begin
          win_cnt_r <= win_cnt_r + 1'b1;
        end
      end

      if (!req_i || acc_i) begin
        starve_i_r <= '0;
      end else if (starve_i_r != STARVE_MAX) begin
        starve_i_r <= starve_i_r + 1'b1;
      end

      if (!req_d || acc_d) begin
        starve_d_r <= '0;
      end else if (starve_d_r != STARVE_MAX) begin
        starve_d_r <= starve_d_r + 1'b1;
      end
    end
  end

  mem_tag_tracker u_tag_tracker (
    .clk       (clk),
    .rst       (rst),
    .acc_vld   (accept),
    .acc_tag   (mem2proc_response_i),
    .acc_side  (grant),
    .ret_tag   (mem2proc_tag_i),
    .i_tag_vld (Imem_tag_vld_o),
    .d_tag_vld (Dmem_tag_vld_o),
    .err_tag   (err_tag_o)
  );

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_I_grant_o  <= '0;
      perf_D_grant_o  <= '0;
      perf_conflict_o <= '0;
    end else begin
      if (acc_i) begin
        perf_I_grant_o <= perf_I_grant_o + 1'b1;
      end
      if (acc_d) begin
        perf_D_grant_o <= perf_D_grant_o + 1'b1;
      end
      if (contend) begin
        perf_conflict_o <= perf_conflict_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a behavioural model of the arbitration and tag rules.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

module tb_mem_port_arbiter;

  localparam logic [1:0] NONE  = `BUS_NONE;
  localparam logic [1:0] LOAD  = `BUS_LOAD;
  localparam logic [1:0] STORE = `BUS_STORE;
  localparam int IW = 2;
  localparam int DW = 2;
  localparam int STARVE = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  ic, dc;
  logic [63:0] ia, da, dd;
  logic [3:0]  rsp, tag;
  logic [3:0]  irsp, drsp;
  logic        itag, dtag, err;
  logic [1:0]  cmd;
  logic [63:0] addr, data;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  int checks = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .Imem_command_i       (ic),
    .Imem_addr_i          (ia),
    .Imem2proc_response_o (irsp),
    .Imem_tag_vld_o       (itag),
    .Dmem_command_i       (dc),
    .Dmem_addr_i          (da),
    .Dmem_data_i          (dd),
    .Dmem2proc_response_o (drsp),
    .Dmem_tag_vld_o       (dtag),
    .mem2proc_response_i  (rsp),
    .mem2proc_tag_i       (tag),
    .proc2mem_command_o   (cmd),
    .proc2mem_addr_o      (addr),
    .proc2mem_data_o      (data),
    .err_tag_o            (err)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_I_grant_o       (perf_i),
    .perf_D_grant_o       (perf_d),
    .perf_conflict_o      (perf_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_prio, m_cnt, m_si, m_sd;   // side 0 = I, 1 = D
  bit m_vld [16];
  int m_own [16];
  bit m_err;
  logic [1:0]  e_cmd;
  logic [63:0] e_addr;
  logic [3:0]  e_irsp, e_drsp;
  logic        e_itag, e_dtag, e_err;

  task automatic model_reset();
    m_prio = 0; m_cnt = 0; m_si = 0; m_sd = 0; m_err = 0;
    for (int t = 0; t < 16; t++) begin
      m_vld[t] = 0;
      m_own[t] = 0;
    end
  endtask

  function automatic int m_grant(input bit ri, input bit rd);
    bit si, sd;
    si = (m_si >= STARVE);
    sd = (m_sd >= STARVE);
    if (ri && rd) return (si != sd) ? int'(sd) : m_prio;
    return rd ? 1 : 0;
  endfunction

  task automatic model_step(input logic [1:0] ic_v, input logic [63:0] ia_v, input logic [1:0] dc_v,
                            input logic [63:0] da_v, input logic [3:0] rsp_v, input logic [3:0] tag_v);
    bit ri, rd, any, acc, hit, si, sd;
    int g;
    ri  = (ic_v != NONE);
    rd  = (dc_v != NONE);
    any = ri || rd;
    g   = m_grant(ri, rd);
    si  = (m_si >= STARVE);
    sd  = (m_sd >= STARVE);
    e_cmd  = !any ? NONE : (g == 1 ? dc_v : ic_v);
    e_addr = (any && g == 1) ? da_v : ia_v;
    e_irsp = (any && g == 0) ? rsp_v : 4'd0;
    e_drsp = (any && g == 1) ? rsp_v : 4'd0;
    acc    = any && (rsp_v != 0);
    hit    = (tag_v != 0) && m_vld[tag_v];
    e_itag = hit && (m_own[tag_v] == 0);
    e_dtag = hit && (m_own[tag_v] == 1);
    e_err  = m_err;
    if (tag_v != 0 && !m_vld[tag_v]) m_err = 1;
    if (acc && m_vld[rsp_v] && !(hit && tag_v == rsp_v)) m_err = 1;
    if (hit) m_vld[tag_v] = 0;
    if (acc) begin
      m_vld[rsp_v] = 1;
      m_own[rsp_v] = g;
    end
    if (ri && rd) begin
      if (si != sd) begin
        m_prio = 1 - g;
        m_cnt  = 0;
      end else begin
        m_cnt++;
        if (m_cnt == (m_prio == 1 ? DW : IW)) begin
          m_prio = 1 - m_prio;
          m_cnt  = 0;
        end
      end
    end
    m_si = (!ri || (acc && g == 0)) ? 0 : ((m_si < STARVE) ? m_si + 1 : m_si);
    m_sd = (!rd || (acc && g == 1)) ? 0 : ((m_sd < STARVE) ? m_sd + 1 : m_sd);
  endtask

  task automatic check_model(input string pre);
    chk({pre, "_cmd"},  cmd,  e_cmd);
    chk({pre, "_addr"}, addr, e_addr);
    chk({pre, "_data"}, data, dd);
    chk({pre, "_irsp"}, irsp, e_irsp);
    chk({pre, "_drsp"}, drsp, e_drsp);
    chk({pre, "_itag"}, itag, e_itag);
    chk({pre, "_dtag"}, dtag, e_dtag);
    chk({pre, "_err"},  err,  e_err);
  endtask

  task automatic drive_idle();
    ic = NONE; dc = NONE; rsp = 4'd0; tag = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  ic;  logic [63:0] ia;  logic [1:0] dc;  logic [63:0] da;
    logic [3:0]  rsp; logic [3:0]  tag;
    logic [1:0]  cmd; logic [63:0] addr; logic [3:0] irsp; logic [3:0] drsp;
    logic        itag; logic dtag; logic err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [1:0] ic_v, input logic [63:0] ia_v, input logic [1:0] dc_v,
                              input logic [63:0] da_v, input logic [3:0] rsp_v, input logic [3:0] tag_v,
                              input logic [1:0] cmd_v, input logic [63:0] addr_v, input logic [3:0] irsp_v,
                              input logic [3:0] drsp_v, input logic itag_v, input logic dtag_v,
                              input logic err_v);
    vec_t v;
    v.ic = ic_v; v.ia = ia_v; v.dc = dc_v; v.da = da_v; v.rsp = rsp_v; v.tag = tag_v;
    v.cmd = cmd_v; v.addr = addr_v; v.irsp = irsp_v; v.drsp = drsp_v;
    v.itag = itag_v; v.dtag = dtag_v; v.err = err_v;
    return v;
  endfunction

  logic [1:0] st_grant [10];
  logic [3:0] st_rsp   [10];

  initial begin
    //              ic     ia     dc     da     rsp tag   cmd    addr   irsp drsp it dt er
    vecs[0]  = mk(NONE, 'h040, NONE,  'h300, 0, 0,  NONE,  'h040, 0, 0, 0, 0, 0);
    vecs[1]  = mk(LOAD, 'h100, NONE,  'h300, 3, 0,  LOAD,  'h100, 3, 0, 0, 0, 0);
    vecs[2]  = mk(NONE, 'h100, NONE,  'h300, 0, 3,  NONE,  'h100, 0, 0, 1, 0, 0);
    vecs[3]  = mk(LOAD, 'h200, STORE, 'h300, 1, 0,  LOAD,  'h200, 1, 0, 0, 0, 0);
    vecs[4]  = mk(LOAD, 'h200, STORE, 'h300, 5, 0,  LOAD,  'h200, 5, 0, 0, 0, 0);
    vecs[5]  = mk(LOAD, 'h200, STORE, 'h300, 6, 0,  STORE, 'h300, 0, 6, 0, 0, 0);
    vecs[6]  = mk(LOAD, 'h200, STORE, 'h300, 2, 0,  STORE, 'h300, 0, 2, 0, 0, 0);
    vecs[7]  = mk(LOAD, 'h200, STORE, 'h300, 3, 0,  LOAD,  'h200, 3, 0, 0, 0, 0);
    vecs[8]  = mk(LOAD, 'h200, STORE, 'h300, 4, 0,  LOAD,  'h200, 4, 0, 0, 0, 0);
    vecs[9]  = mk(NONE, 'h200, NONE,  'h300, 0, 6,  NONE,  'h200, 0, 0, 0, 1, 0);
    vecs[10] = mk(NONE, 'h200, NONE,  'h300, 0, 5,  NONE,  'h200, 0, 0, 1, 0, 0);
    vecs[11] = mk(NONE, 'h200, NONE,  'h300, 0, 0,  NONE,  'h200, 0, 0, 0, 0, 0);
    vecs[12] = mk(NONE, 'h200, LOAD,  'h300, 1, 1,  LOAD,  'h300, 0, 1, 1, 0, 0);
    vecs[13] = mk(NONE, 'h200, NONE,  'h300, 0, 1,  NONE,  'h200, 0, 0, 0, 1, 0);
    vecs[14] = mk(NONE, 'h200, LOAD,  'h300, 0, 0,  LOAD,  'h300, 0, 0, 0, 0, 0);
    vecs[15] = mk(NONE, 'h200, NONE,  'h300, 0, 9,  NONE,  'h200, 0, 0, 0, 0, 0);
    vecs[16] = mk(NONE, 'h200, NONE,  'h300, 0, 0,  NONE,  'h200, 0, 0, 0, 0, 1);
    vecs[17] = mk(LOAD, 'h100, NONE,  'h300, 0, 0,  LOAD,  'h100, 0, 0, 0, 0, 1);

    st_grant = '{LOAD, LOAD, STORE, STORE, LOAD, LOAD, STORE, STORE, STORE, LOAD};
    st_rsp   = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 4'd4, 4'd0, 4'd0, 4'd5, 4'd6};

    // reset with live requests driven: everything must stay quiet
    rst = 1'b0;
    ic = LOAD; dc = STORE; ia = 64'h100; da = 64'h300; dd = 64'hD00D_CAFE_0000_1234;
    rsp = 4'd3; tag = 4'd5;
    #7;
    chk("rst_cmd",  cmd,  NONE);
    chk("rst_irsp", irsp, 0);
    chk("rst_drsp", drsp, 0);
    chk("rst_itag", itag, 0);
    chk("rst_dtag", dtag, 0);
    chk("rst_err",  err,  0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ic = vecs[i].ic; ia = vecs[i].ia; dc = vecs[i].dc; da = vecs[i].da;
      rsp = vecs[i].rsp; tag = vecs[i].tag;
      #2;
      chk($sformatf("vec%0d_cmd", i),  cmd,  vecs[i].cmd);
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
      chk($sformatf("vec%0d_irsp", i), irsp, vecs[i].irsp);
      chk($sformatf("vec%0d_drsp", i), drsp, vecs[i].drsp);
      chk($sformatf("vec%0d_itag", i), itag, vecs[i].itag);
      chk($sformatf("vec%0d_dtag", i), dtag, vecs[i].dtag);
      chk($sformatf("vec%0d_err", i),  err,  vecs[i].err);
    end

    // asynchronous reset in the middle of a cycle clears the sticky error and the tag table
    @(negedge clk);
    ic = LOAD; dc = NONE; rsp = 4'd3; tag = 4'd2;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cmd",  cmd,  NONE);
    chk("async_rst_irsp", irsp, 0);
    chk("async_rst_dtag", dtag, 0);
    chk("async_rst_err",  err,  0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    model_reset();

    // starvation: D is rejected whenever it wins, I accepted, until D's starve count saturates
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ic = LOAD; ia = 64'h1000; dc = STORE; da = 64'h2000; rsp = st_rsp[i]; tag = 4'd0;
      #2;
      chk($sformatf("starve%0d_grant", i), cmd, st_grant[i]);
      chk($sformatf("starve%0d_rsp", i), (st_grant[i] == STORE) ? drsp : irsp, st_rsp[i]);
    end

`ifdef MEM_ARB_PERF_EN
    do_reset();
    #1;
    chk("perf_reset_conflict", perf_c, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ic = LOAD; dc = LOAD; rsp = 4'(i + 1); tag = 4'd0;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("perf_conflict", perf_c, 10);
    chk("perf_sum", perf_i + perf_d, 10);
    chk("perf_i", perf_i, 6);
`endif

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r, s, g;
      @(negedge clk);
      r  = $urandom_range(0, 9);
      ic = (r < 4) ? NONE : LOAD;
      r  = $urandom_range(0, 9);
      dc = (r < 4) ? NONE : ((r < 7) ? LOAD : STORE);
      ia = {$urandom, $urandom};
      da = {$urandom, $urandom};
      dd = {$urandom, $urandom};
      g  = m_grant(ic != NONE, dc != NONE);
      rsp = 4'd0;
      // second half: memory keeps rejecting D to push it into starvation
      if ($urandom_range(0, 9) < 7 && !(n >= 200 && g == 1 && $urandom_range(0, 9) < 8)) begin
        s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
          int t;
          t = ((s + k) % 15) + 1;
          if (rsp == 0 && !m_vld[t]) rsp = 4'(t);
        end
      end
      tag = 4'd0;
      if ($urandom_range(0, 9) < 4) begin
        s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
          int t;
          t = ((s + k) % 15) + 1;
          if (tag == 0 && m_vld[t]) tag = 4'(t);
        end
      end
      model_step(ic, ia, dc, da, rsp, tag);
      #2;
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
